muldiv_hilo_seq: RTL and testbench

//  Multi-cycle multiply/divide sequencer owning the MIPS HI/LO registers. Executes MULT, MULTU,
//  DIV, DIVU iteratively (1 bit/cycle shift-add / restoring divide) and MTHI/MTLO single-cycle

---
 rtl/muldiv_hilo_seq.sv | 162 ++++++++++++++++
 tb/tb_muldiv_hilo_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_seq.sv
// Iterative MIPS multiply/divide unit owning HI/LO: 1 bit/cycle shift-add multiply and
// restoring divide on magnitudes, sign fix-up in a final cycle, plus single-cycle MTHI/MTLO.
module muldiv_hilo_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  // Handshake: start is a request accepted only on an edge where busy=0 and cancel=0;
  // the unit owns the operation until done pulses (or cancel/reset abort it).
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]  dvs;
  logic [WIDTH-1:0]  a_orig;
  logic              sign_q;
  logic              sign_r;
  logic              dz_q;
  logic              is_div;

  logic              signed_op;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH:0]    div_trial;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]  quo_fix;
  logic [WIDTH-1:0]  rem_fix;

  assign dbg_state = state;

  always_comb begin
    signed_op = ~op[0];
    a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

    // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend bits / quotient bits}; remainder < divisor always,
    // so a borrow out of bit WIDTH means the trial subtraction must be undone.
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, dvs};
    div_next  = {(div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                 acc[WIDTH-2:0], ~div_trial[WIDTH]};

    prod_fix = sign_q ? -acc : acc;
    quo_fix  = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      dvs      <= '0;
      a_orig   <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      dz_q     <= 1'b0;
      is_div   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !cancel) begin
            case (op)
              3'b000, 3'b001: begin
                state  <= S_MUL;
                busy   <= 1'b1;
                cnt    <= '0;
                acc    <= {{WIDTH{1'b0}}, b_mag};
                dvs    <= a_mag;
                sign_q <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                sign_r <= 1'b0;
                dz_q   <= 1'b0;
                is_div <= 1'b0;
              end
              3'b010, 3'b011: begin
                state  <= S_DIV;
                busy   <= 1'b1;
                cnt    <= '0;
                acc    <= {{WIDTH{1'b0}}, a_mag};
                dvs    <= b_mag;
                a_orig <= a;
                sign_q <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                sign_r <= signed_op & a[WIDTH-1];
                dz_q   <= (b == '0);
                is_div <= 1'b1;
              end
              3'b100:  hi <= a;
              3'b101:  lo <= a;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (cancel) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CW'(WIDTH)) begin
            state <= S_FIX;
          end else begin
            acc <= (state == S_MUL) ? mul_next : div_next;
            cnt <= cnt + 1'b1;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
          if (!cancel) begin
            done <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= prod_fix;
            end else if (dz_q) begin
              hi       <= a_orig;
              lo       <= '1;
              div_zero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_seq.sv
// Bench for muldiv_hilo_seq: arithmetic reference model checked every cycle, plus
// hand-computed expectations for the directed vectors.
module tb_muldiv_hilo_seq;
  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cancel;
  logic          busy;
  logic          done;
  logic          div_zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [1:0]    dbg_state;

  int tests = 0;
  int fails = 0;

  muldiv_hilo_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic         exp_busy = 1'b0;
  logic         exp_done = 1'b0;
  logic         exp_dz   = 1'b0;
  logic [W-1:0] exp_hi   = '0;
  logic [W-1:0] exp_lo   = '0;
  logic [W-1:0] pend_hi  = '0;
  logic [W-1:0] pend_lo  = '0;
  logic         pend_dz  = 1'b0;
  int           cd       = 0;

  function automatic void calc(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
    longint          sx, sy, q, r;
    longint unsigned ux, uy;
    logic [63:0]     p;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    dz = 1'b0;
    h  = '0;
    l  = '0;
    if (o == 3'b000) begin
      p = sx * sy;
      {h, l} = p;
    end else if (o == 3'b001) begin
      p = ux * uy;
      {h, l} = p;
    end else if (y == '0) begin
      h  = x;
      l  = '1;
      dz = 1'b1;
    end else if (o == 3'b010) begin
      q = sx / sy;
      r = sx % sy;
      l = q[W-1:0];
      h = r[W-1:0];
    end else begin
      l = W'(ux / uy);
      h = W'(ux % uy);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_dz   = 1'b0;
      exp_hi   = '0;
      exp_lo   = '0;
      cd       = 0;
    end else begin
      exp_done = 1'b0;
      exp_dz   = 1'b0;
      if (exp_busy) begin
        if (cancel) begin
          exp_busy = 1'b0;
        end else begin
          cd = cd - 1;
          if (cd == 0) begin
            exp_busy = 1'b0;
            exp_done = 1'b1;
            exp_dz   = pend_dz;
            exp_hi   = pend_hi;
            exp_lo   = pend_lo;
          end
        end
      end else if (start && !cancel) begin
        if (op <= 3'b011) begin
          calc(op, a, b, pend_hi, pend_lo, pend_dz);
          exp_busy = 1'b1;
          cd       = W + 2;
        end else if (op == 3'b100) begin
          exp_hi = a;
        end else if (op == 3'b101) begin
          exp_lo = a;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_busy", W'(busy), W'(exp_busy));
    chk("cyc_done", W'(done), W'(exp_done));
    chk("cyc_div_zero", W'(div_zero), W'(exp_dz));
    chk("cyc_hi", hi, exp_hi);
    chk("cyc_lo", lo, exp_lo);
  end

  // ---------------- drivers ----------------
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int nb, output logic dz_seen);
    logic got;
    got     = 1'b0;
    nb      = 0;
    dz_seen = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got     = 1'b1;
        dz_seen = div_zero;
      end else if (busy) begin
        nb++;
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s_timeout: got no done, expected done within 60 cycles", name);
    end
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    int   nb;
    logic dz;
    int   done_cnt;
    rst_n  = 1'b1;
    start  = 1'b0;
    cancel = 1'b0;
    op     = '0;
    a      = '0;
    b      = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", W'(busy), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    issue(3'b000, 32'hFFFF_FFFD, 32'h0000_0005);
    wait_done("mult", nb, dz);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);
    chk("mult_busy_cycles", W'(nb), 32'd34);

    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu", nb, dz);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    chk("multu_busy_cycles", W'(nb), 32'd34);

    issue(3'b010, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done("div_neg", nb, dz);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    // issued from inside the done cycle: accepted at its closing edge
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", nb, dz);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0000_0000);
    chk("div_ovf_dz", W'(dz), 32'h0);
    chk("b2b_busy_cycles", W'(nb), 32'd34);

    issue(3'b010, 32'h0000_0007, 32'hFFFF_FFFE);
    wait_done("div_negb", nb, dz);
    chk("div_negb_lo", lo, 32'hFFFF_FFFD);
    chk("div_negb_hi", hi, 32'h0000_0001);

    issue(3'b011, 32'h0000_1234, 32'h0000_0000);
    wait_done("divu_zero", nb, dz);
    chk("divu_zero_lo", lo, 32'hFFFF_FFFF);
    chk("divu_zero_hi", hi, 32'h0000_1234);
    chk("divu_zero_flag", W'(dz), 32'h1);
    @(negedge clk);
    chk("divu_zero_flag_once", W'(div_zero), 32'h0);

    issue(3'b000, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_minmin", nb, dz);
    chk("mult_minmin_hi", hi, 32'h4000_0000);
    chk("mult_minmin_lo", lo, 32'h0000_0000);

    issue(3'b100, 32'hA5A5_A5A5, 32'h0);
    chk("mthi_hi", hi, 32'hA5A5_A5A5);
    chk("mthi_busy", W'(busy), 32'h0);
    issue(3'b101, 32'h0000_0011, 32'h0);
    chk("mtlo_lo", lo, 32'h0000_0011);
    issue(3'b110, 32'h7777_7777, 32'h1);
    chk("invalid_busy", W'(busy), 32'h0);

    // MTLO while busy must not touch lo
    issue(3'b011, 32'd100, 32'd7);
    issue(3'b101, 32'h0000_DEAD, 32'h0);
    wait_done("divu_mtlo", nb, dz);
    chk("divu_mtlo_lo", lo, 32'h0000_000E);
    chk("divu_mtlo_hi", hi, 32'h0000_0002);

    // cancel after 10 cycles of a DIV
    issue(3'b010, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    chk("cancel_busy", W'(busy), 32'h0);
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("cancel_no_done", W'(done_cnt), 32'h0);
    chk("cancel_hi", hi, 32'h0000_0002);
    chk("cancel_lo", lo, 32'h0000_000E);

    // cancel in IDLE blocks a same-cycle MTHI
    cancel = 1'b1;
    issue(3'b100, 32'h0000_5555, 32'h0);
    cancel = 1'b0;
    chk("idle_cancel_hi", hi, 32'h0000_0002);

    // reset in the middle of a MULT
    issue(3'b000, 32'h0000_0003, 32'h0000_0004);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_hi", hi, 32'h0);
    chk("midreset_lo", lo, 32'h0);
    chk("midreset_busy", W'(busy), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    issue(3'b001, 32'h0001_0000, 32'h0001_0000);
    wait_done("multu_after_reset", nb, dz);
    chk("multu_after_reset_hi", hi, 32'h0000_0001);
    chk("multu_after_reset_lo", lo, 32'h0000_0000);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
